// File: rtl/obi_err_log_drain_pkg.sv
// Shared types and default register map for the OBI error-log drain.
package obi_err_log_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_CODE = 2'd2,
    ST_POP     = 2'd3
  } drain_state_e;

  localparam int unsigned DefRegDataWidth = 32;
  localparam int unsigned DefRegAddrWidth = 32;

  localparam logic [DefRegAddrWidth-1:0] DefErrAddrOffset = 32'h0;
  localparam logic [DefRegAddrWidth-1:0] DefErrCodeOffset = 32'h4;
  localparam logic [DefRegAddrWidth-1:0] DefPopOffset     = 32'h8;

  typedef struct packed {
    logic [DefRegAddrWidth-1:0]   addr;
    logic                         write;
    logic [DefRegDataWidth-1:0]   wdata;
    logic [DefRegDataWidth/8-1:0] wstrb;
    logic                         valid;
  } obi_reg_req_t;

  typedef struct packed {
    logic [DefRegDataWidth-1:0] rdata;
    logic                       error;
    logic                       ready;
  } obi_reg_rsp_t;

endpackage

// File: rtl/obi_err_rec_fifo.sv
// Synchronous-reset first-word-fall-through FIFO for drained error records.
module obi_err_rec_fifo #(
  parameter int unsigned DataWidth = 33,
  parameter int unsigned Depth     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   pop_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] usage_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]        cnt_q, cnt_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_err_log_drain.sv
// Drains the oldest bus-error log entry on IRQ and streams {addr, err} records out.
//   state   | meaning
//   IDLE    | waiting for IRQ with room in the record FIFO
//   RD_ADDR | reading the oldest logged address
//   RD_CODE | reading the oldest error code (0 = log empty, spurious IRQ)
//   POP     | writing 1 to the pop register; record pushed on completion
module obi_err_log_drain
  import obi_err_log_drain_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned ErrBits       = 1,
  parameter int unsigned RegDataWidth  = DefRegDataWidth,
  parameter int unsigned RegAddrWidth  = DefRegAddrWidth,
  parameter logic [RegAddrWidth-1:0] ErrAddrOffset = RegAddrWidth'(DefErrAddrOffset),
  parameter logic [RegAddrWidth-1:0] ErrCodeOffset = RegAddrWidth'(DefErrCodeOffset),
  parameter logic [RegAddrWidth-1:0] PopOffset     = RegAddrWidth'(DefPopOffset),
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 255,
  parameter type reg_req_t = obi_reg_req_t,
  parameter type reg_rsp_t = obi_reg_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 err_irq_i,
  output reg_req_t             reg_req_o,
  input  reg_rsp_t             reg_rsp_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [AddrWidth-1:0] rec_addr_o,
  output logic [ErrBits-1:0]   rec_err_o,
  input  logic                 clr_i,
  output logic                 timeout_o,
  output logic                 bus_err_o,
  output logic [15:0]          drained_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [ErrBits-1:0]   err;
  } rec_t;

  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(TimeoutCycles - 1);

  drain_state_e         state_q, state_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [ErrBits-1:0]   code_q, code_d;
  logic                 timeout_q, timeout_d;
  logic                 bus_err_q, bus_err_d;
  logic [15:0]          drained_q, drained_d;
  logic                 push;
  logic                 fifo_full, fifo_empty;
  logic [$clog2(FifoDepth):0] unused_usage;
  rec_t                 rec_in, rec_out;

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    addr_d    = addr_q;
    code_d    = code_q;
    timeout_d = timeout_q;
    bus_err_d = bus_err_q;
    drained_d = drained_q;
    push      = 1'b0;
    if (state_q == ST_IDLE) begin
      if (err_irq_i && !fifo_full) begin
        state_d   = ST_RD_ADDR;
        tmo_cnt_d = TmoLoad;
      end
    end else if (reg_rsp_i.ready) begin
      tmo_cnt_d = TmoLoad;
      if (reg_rsp_i.error) begin
        bus_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        case (state_q)
          ST_RD_ADDR: begin
            addr_d  = reg_rsp_i.rdata[AddrWidth-1:0];
            state_d = ST_RD_CODE;
          end
          ST_RD_CODE: begin
            code_d  = reg_rsp_i.rdata[ErrBits-1:0];
            state_d = (reg_rsp_i.rdata[ErrBits-1:0] == '0) ? ST_IDLE : ST_POP;
          end
          ST_POP: begin
            push    = 1'b1;
            state_d = ST_IDLE;
            if (drained_q != 16'hFFFF) drained_d = drained_q + 16'd1;
          end
          default: ;
        endcase
      end
    end else if (tmo_cnt_q == '0) begin
      timeout_d = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
    // Clear beats any same-cycle flag set or count increment.
    if (clr_i) begin
      timeout_d = 1'b0;
      bus_err_d = 1'b0;
      drained_d = 16'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      addr_q    <= '0;
      code_q    <= '0;
      timeout_q <= 1'b0;
      bus_err_q <= 1'b0;
      drained_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      addr_q    <= addr_d;
      code_q    <= code_d;
      timeout_q <= timeout_d;
      bus_err_q <= bus_err_d;
      drained_q <= drained_d;
    end
  end

  always_comb begin
    reg_req_o = '0;
    case (state_q)
      ST_RD_ADDR: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = ErrAddrOffset;
      end
      ST_RD_CODE: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = ErrCodeOffset;
      end
      ST_POP: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = PopOffset;
        reg_req_o.write = 1'b1;
        reg_req_o.wdata = {{(RegDataWidth-1){1'b0}}, 1'b1};
        reg_req_o.wstrb = '1;
      end
      default: ;
    endcase
  end

  assign rec_in = '{addr: addr_q, err: code_q};

  obi_err_rec_fifo #(
    .DataWidth ($bits(rec_t)),
    .Depth     (FifoDepth)
  ) u_rec_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (rec_ready_i),
    .data_o  (rec_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (unused_usage)
  );

  assign rec_valid_o = !fifo_empty;
  assign rec_addr_o  = rec_out.addr;
  assign rec_err_o   = rec_out.err;
  assign timeout_o   = timeout_q;
  assign bus_err_o   = bus_err_q;
  assign drained_o   = drained_q;

endmodule

// File: tb/tb_obi_err_log_drain.sv
// Bench for obi_err_log_drain: error-log slave, record-stream model, directed scenarios.
module tb_obi_err_log_drain;
  import obi_err_log_drain_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic rec_ready = 1'b0;
  logic clr = 1'b0;
  obi_reg_req_t req;
  obi_reg_rsp_t rsp;
  logic        rec_valid;
  logic [31:0] rec_addr;
  logic [0:0]  rec_err;
  logic        timeout, bus_err;
  logic [15:0] drained;

  always #5 clk = ~clk;

  obi_err_log_drain #(
    .FifoDepth     (4),
    .TimeoutCycles (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .err_irq_i   (irq),
    .reg_req_o   (req),
    .reg_rsp_i   (rsp),
    .rec_valid_o (rec_valid),
    .rec_ready_i (rec_ready),
    .rec_addr_o  (rec_addr),
    .rec_err_o   (rec_err),
    .clr_i       (clr),
    .timeout_o   (timeout),
    .bus_err_o   (bus_err),
    .drained_o   (drained)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Error-log slave: a simple FIFO of {addr, code} behind the three registers.
  logic        irq_force = 1'b0, irq_auto = 1'b0, slave_ready = 1'b1, err_on_pop = 1'b0;
  logic [31:0] log_addr [16];
  logic        log_code [16];
  int          log_rd = 0, log_wr = 0, pops = 0, wr_seen = 0, handshakes = 0;
  logic        log_nonempty, pop_now, hs;

  assign log_nonempty = (log_wr != log_rd);
  assign irq     = irq_force || (irq_auto && log_nonempty);
  assign pop_now = req.valid && rsp.ready && !rsp.error && req.write &&
                   (req.addr == 32'h8) && req.wdata[0] && log_nonempty;
  assign hs      = rec_valid && rec_ready;

  always_comb begin
    rsp       = '0;
    rsp.ready = slave_ready;
    rsp.error = err_on_pop && req.write;
    if (log_nonempty) begin
      if (req.addr == 32'h0) rsp.rdata = log_addr[log_rd];
      else if (req.addr == 32'h4) rsp.rdata = {31'b0, log_code[log_rd]};
    end
  end

  // Model: every entry popped from the log must come out of the stream, in order.
  logic [32:0] exp_q[$];
  logic [15:0] exp_drained = 16'd0;

  always @(posedge clk) begin
    if (hs) handshakes <= handshakes + 1;
    if (req.valid && req.write) wr_seen <= wr_seen + 1;
    if (pop_now) begin
      log_rd <= log_rd + 1;
      pops   <= pops + 1;
    end
    if (rst) begin
      exp_q.delete();
      exp_drained <= 16'd0;
    end else begin
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pop_now) exp_q.push_back({log_addr[log_rd], log_code[log_rd]});
      if (clr) exp_drained <= 16'd0;
      else if (pop_now && exp_drained != 16'hFFFF) exp_drained <= exp_drained + 16'd1;
    end
  end

  obi_reg_req_t prev_req;
  logic         prev_valid = 1'b0, prev_ready = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      chk("rec_valid_model", rec_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("rec_data_model", {rec_addr, rec_err}, exp_q[0]);
      chk("drained_model", drained, exp_drained);
      if (prev_valid && !prev_ready && req.valid) chk("req_stable", req, prev_req);
      prev_req   <= req;
      prev_valid <= req.valid;
      prev_ready <= rsp.ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic log_push(input logic [31:0] a, input logic c);
    log_addr[log_wr] = a;
    log_code[log_wr] = c;
    log_wr++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, h0, n;
    tick(3);
    chk("rst_req_valid", req.valid, 1'b0);
    chk("rst_rec_valid", rec_valid, 1'b0);
    chk("rst_flags", {timeout, bus_err}, 2'b00);
    chk("rst_drained", drained, 16'd0);
    rst = 1'b0;
    tick(1);

    // Single drain, latency to record.
    log_push(32'h1000_0040, 1'b1);
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    chk("t1_rd_addr", {req.valid, req.write, req.addr}, {2'b10, 32'h0});
    tick(1);
    chk("t1_rd_code", {req.valid, req.write, req.addr}, {2'b10, 32'h4});
    tick(1);
    chk("t1_pop", {req.valid, req.write, req.addr, req.wdata, req.wstrb},
        {2'b11, 32'h8, 32'h1, 4'hF});
    chk("t1_no_rec_yet", rec_valid, 1'b0);
    tick(1);
    chk("t1_rec_valid_c4", rec_valid, 1'b1);
    chk("t1_rec_data", {rec_addr, rec_err}, {32'h1000_0040, 1'b1});
    chk("t1_drained", drained, 16'd1);
    chk("t1_req_idle", req.valid, 1'b0);
    rec_ready = 1'b1;
    tick(1);
    rec_ready = 1'b0;
    chk("t1_consumed", rec_valid, 1'b0);

    // Spurious IRQ: empty log reads code 0, no pop.
    p0 = pops; w0 = wr_seen;
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    tick(2);
    chk("t2_idle", req.valid, 1'b0);
    tick(5);
    chk("t2_no_pop_write", wr_seen - w0, 0);
    chk("t2_no_rec", rec_valid, 1'b0);
    chk("t2_drained", drained, 16'd1);

    // Backpressure: six entries, FIFO of four.
    for (int i = 0; i < 6; i++) log_push(32'h2000_0000 + 32'(i * 16), 1'b1);
    p0 = pops; h0 = handshakes;
    irq_auto = 1'b1;
    tick(40);
    chk("t3_pops_full", pops - p0, 4);
    chk("t3_fsm_idle", req.valid, 1'b0);
    chk("t3_head", {rec_valid, rec_addr, rec_err}, {1'b1, 32'h2000_0000, 1'b1});
    chk("t3_log_left", log_wr - log_rd, 2);
    rec_ready = 1'b1;
    n = 0;
    while ((log_nonempty || rec_valid) && n < 100) begin
      tick(1);
      n++;
    end
    chk("t3_drain_bound", n < 100, 1'b1);
    chk("t3_pops_all", pops - p0, 6);
    chk("t3_hs_all", handshakes - h0, 6);
    chk("t3_drained", drained, 16'd7);
    irq_auto = 1'b0;
    rec_ready = 1'b0;
    tick(2);

    // Timeout: slave never ready.
    slave_ready = 1'b0;
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    tick(7);
    chk("t4_still_waiting", {req.valid, timeout}, 2'b10);
    tick(1);
    chk("t4_timed_out", {req.valid, timeout}, 2'b01);
    slave_ready = 1'b1;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t4_clr", {timeout, bus_err, drained}, 18'd0);

    // Response error on the pop write.
    log_push(32'h3000_0000, 1'b1);
    err_on_pop = 1'b1;
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    tick(3);
    chk("t5_bus_err", bus_err, 1'b1);
    chk("t5_no_rec", rec_valid, 1'b0);
    chk("t5_drained", drained, 16'd0);
    chk("t5_entry_kept", log_wr - log_rd, 1);
    chk("t5_idle", req.valid, 1'b0);
    err_on_pop = 1'b0;

    // Reset during RD_CODE, then replay.
    p0 = pops;
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    tick(1);
    chk("t6_in_rd_code", {req.valid, req.addr}, {1'b1, 32'h4});
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_rst_valid", {req.valid, rec_valid, bus_err}, 3'b000);
    irq_force = 1'b1;
    tick(1);
    irq_force = 1'b0;
    tick(3);
    chk("t6_replay_rec", {rec_valid, rec_addr, rec_err}, {1'b1, 32'h3000_0000, 1'b1});
    chk("t6_drained", drained, 16'd1);
    rec_ready = 1'b1;
    tick(1);
    rec_ready = 1'b0;
    tick(5);
    chk("t6_pop_once", pops - p0, 1);
    chk("t6_empty", {rec_valid, log_nonempty}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
